serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor with borrow-in. It computes oData = iData_a - iData_b - iB using one full-subtractor cell, LSB first, one bit per clock. It is the inverse-operation companion to the team's combinational adder, and is used where area matters more than latency. A start/busy/done handshake lets a controller sequence operations.

Parameters:
WIDTH, 8, operand and result width in bits (WIDTH >= 2); bit counter width = clog2(WIDTH).

Ports:
iClk  input  1  system clock, rising-edge.
iRst  input  1  asynchronous, active-high reset.
iStart  input  1  request a new subtraction; sampled on the rising edge.
iData_a  input  WIDTH  minuend; captured on the accepting edge.
iData_b  input  WIDTH  subtrahend; captured on the accepting edge.
iB  input  1  borrow-in; captured on the accepting edge.
oData  output  WIDTH  difference, registered; holds the last completed result.
oData_B  output  1  borrow-out of the MSB, registered; holds with oData.
oBusy  output  1  high while an operation is in progress (RUN state).
oDone  output  1  one-cycle pulse: oData/oData_B just updated.

Behaviour:
- Reset (iRst=1, asynchronous, any state):
  - state=IDLE; oData=0; oData_B=0; oBusy=0; oDone=0.
  - internal shift registers, borrow flop and bit counter cleared.
  - an operation in flight is abandoned; no oDone is issued for it.
- FSM states: IDLE, RUN, DONE.
  - IDLE: iStart=1 -> capture a, b and iB into the borrow flop; cnt=0; go to RUN. iStart=0 -> stay.
  - RUN: each edge processes bit cnt (LSB first):
    - d = a0 ^ b0 ^ br
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
    - shift d into the result register from the MSB side; shift a and b right.
  - When cnt == WIDTH-1: load oData with the completed result and oData_B with br_next; go to DONE. Otherwise cnt++.
  - DONE: oDone=1 for exactly this cycle. Next edge: iStart=1 -> accept new operands as in IDLE (back-to-back); else go to IDLE.
- Timing and handshake:
  - Accepting edge is E0; bits are processed at edges E1..E_WIDTH.
  - oData, oData_B and oDone are valid in the cycle after E_WIDTH (WIDTH cycles after acceptance).
  - oBusy=1 exactly in RUN, i.e. WIDTH cycles per operation.
  - iStart is ignored in RUN; no queuing and no restart.
  - iData_a, iData_b and iB may change freely after the accepting edge.
  - oData and oData_B change only at completion or reset; they never show partial results.
- Arithmetic: modulo 2^WIDTH.
  - oData_B=1 iff a < b + iB (unsigned).
  - Two's-complement overflow is not flagged.
- Throughput: back-to-back operations start every WIDTH+1 cycles.

Test Plan:
- Reset, then a=0x0D, b=0x02, iB=0, pulse iStart -> oBusy high for 8 cycles; oDone pulses once; oData=0x0B, oData_B=0.
- a=0x0D, b=0x0F, iB=0 -> oData=0xFE, oData_B=1. Then a=0x0B, b=0x0B, iB=1 -> oData=0xFF, oData_B=1.
- Back-to-back: 0x55-0xA6-1 accepted while in DONE, then 0xD5-0xA2-0 -> oData=0xAE/B=1, then oData=0x33/B=0. Each oDone is exactly 1 cycle; operations start 9 cycles apart.
- Drive iStart with a=0xAD, b=0xB2 during RUN of 0x45-0xE2-1 -> the second request is ignored; result oData=0x62, oData_B=1; no extra oDone.
- Assert iRst at bit 4 of 0xAD-0xB2 -> outputs go to 0 immediately; state IDLE. After release, a fresh 0xAD-0xB2-0 -> oData=0xFB, oData_B=1.
- Operands changed on the cycle after acceptance -> result still matches the captured operands; oData holds its previous value until oDone.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b - borrowIn, one full-subtractor cell, LSB first.
// start/busy/done handshake; results update only on completion.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    input  logic             iB,
    output logic [WIDTH-1:0] oData,
    output logic             oData_B,
    output logic             oBusy,
    output logic             oDone
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           stateNext;
    logic [WIDTH-1:0] shA;
    logic [WIDTH-1:0] shB;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] resNext;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             lastBit;
    logic             diffBit;
    logic             borrowNext;

    // Returns {borrowOut, difference} of a - b - bin.
    function automatic logic [1:0] fullSub(input logic a, input logic b, input logic bin);
        logic d;
        logic bo;
        d  = a ^ b ^ bin;
        bo = (~a & b) | (~(a ^ b) & bin);
        return {bo, d};
    endfunction

    always_comb begin
        {borrowNext, diffBit} = fullSub(shA[0], shB[0], br);
        resNext = (res >> 1) | {diffBit, {(WIDTH-1){1'b0}}};
        lastBit = (cnt == LAST_BIT);
        accept  = iStart && ((state == IDLE) || (state == DONE));
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (iStart) stateNext = RUN;
            RUN:     if (lastBit) stateNext = DONE;
            DONE:    stateNext = iStart ? RUN : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state <= IDLE;
        else      state <= stateNext;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            shA     <= '0;
            shB     <= '0;
            res     <= '0;
            br      <= 1'b0;
            cnt     <= '0;
            oData   <= '0;
            oData_B <= 1'b0;
        end else if (accept) begin
            shA <= iData_a;
            shB <= iData_b;
            br  <= iB;
            cnt <= '0;
        end else if (state == RUN) begin
            shA <= shA >> 1;
            shB <= shB >> 1;
            res <= resNext;
            br  <= borrowNext;
            // Publish only the completed word; partial results stay internal.
            if (lastBit) begin
                oData   <= resNext;
                oData_B <= borrowNext;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign oBusy = (state == RUN);
    assign oDone = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=8): handshake timing,
// borrow cases, back-to-back, ignored start, mid-operation reset, operand capture.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         iClk;
    logic         iRst;
    logic         iStart;
    logic [W-1:0] iData_a;
    logic [W-1:0] iData_b;
    logic         iB;
    logic [W-1:0] oData;
    logic         oData_B;
    logic         oBusy;
    logic         oDone;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart),
        .iData_a(iData_a), .iData_b(iData_b), .iB(iB),
        .oData(oData), .oData_B(oData_B), .oBusy(oBusy), .oDone(oDone)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Called 1 time unit after a rising edge with the DUT in IDLE or DONE.
    // Returns at the sample point of the oDone cycle.
    task automatic doOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output int lat, output int busy, output bit to, output time tAcc);
        iData_a = a; iData_b = b; iB = bin; iStart = 1'b1;
        @(posedge iClk); #1;
        tAcc = $time;
        iStart = 1'b0;
        lat = 0; busy = 0; to = 1'b0;
        while (oDone !== 1'b1) begin
            if (oBusy === 1'b1) busy++;
            if (lat >= 20) begin to = 1'b1; break; end
            @(posedge iClk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        iRst = 1'b1; iStart = 1'b0; iData_a = '0; iData_b = '0; iB = 1'b0;
        repeat (2) @(posedge iClk);
        #1;
        checks++; if (oData !== 8'h00) begin errors++; $display("FAIL reset_data got %h expected 00", oData); end
        checks++; if (oData_B !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b expected 0", oData_B); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", oBusy); end
        checks++; if (oDone !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", oDone); end
        iRst = 1'b0;
        @(posedge iClk); #1;
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b expected 0", oBusy); end
    endtask

    task automatic test_basic();
        int lat, busy; bit to; time t;
        doOp(8'h0D, 8'h02, 1'b0, lat, busy, to, t);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got %b expected 0", to); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d expected 8", lat); end
        checks++; if (busy !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d expected 8", busy); end
        checks++; if (oData !== 8'h0B) begin errors++; $display("FAIL basic_data got %h expected 0B", oData); end
        checks++; if (oData_B !== 1'b0) begin errors++; $display("FAIL basic_borrow got %b expected 0", oData_B); end
        @(posedge iClk); #1;
        checks++; if (oDone !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b expected 0", oDone); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b expected 0", oBusy); end
        checks++; if (oData !== 8'h0B) begin errors++; $display("FAIL basic_hold got %h expected 0B", oData); end
    endtask

    task automatic test_borrow();
        int lat, busy; bit to; time t;
        doOp(8'h0D, 8'h0F, 1'b0, lat, busy, to, t);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL neg_timeout got %b expected 0", to); end
        checks++; if (oData !== 8'hFE) begin errors++; $display("FAIL neg_data got %h expected FE", oData); end
        checks++; if (oData_B !== 1'b1) begin errors++; $display("FAIL neg_borrow got %b expected 1", oData_B); end
        @(posedge iClk); #1;
        doOp(8'h0B, 8'h0B, 1'b1, lat, busy, to, t);
        checks++; if (oData !== 8'hFF) begin errors++; $display("FAIL equal_bin_data got %h expected FF", oData); end
        checks++; if (oData_B !== 1'b1) begin errors++; $display("FAIL equal_bin_borrow got %b expected 1", oData_B); end
        @(posedge iClk); #1;
        doOp(8'hFF, 8'h00, 1'b0, lat, busy, to, t);
        checks++; if (oData !== 8'hFF) begin errors++; $display("FAIL max_data got %h expected FF", oData); end
        checks++; if (oData_B !== 1'b0) begin errors++; $display("FAIL max_borrow got %b expected 0", oData_B); end
        @(posedge iClk); #1;
    endtask

    task automatic test_back_to_back();
        int lat1, busy1, lat2, busy2; bit to1, to2; time t1, t2;
        doOp(8'h55, 8'hA6, 1'b1, lat1, busy1, to1, t1);
        checks++; if (oData !== 8'hAE) begin errors++; $display("FAIL b2b1_data got %h expected AE", oData); end
        checks++; if (oData_B !== 1'b1) begin errors++; $display("FAIL b2b1_borrow got %b expected 1", oData_B); end
        doOp(8'hD5, 8'hA2, 1'b0, lat2, busy2, to2, t2);
        checks++; if (to2 !== 1'b0) begin errors++; $display("FAIL b2b2_timeout got %b expected 0", to2); end
        checks++; if ((t2 - t1) !== 90) begin errors++; $display("FAIL b2b_spacing got %0t expected 90", t2 - t1); end
        checks++; if (busy2 !== 8) begin errors++; $display("FAIL b2b2_busy got %0d expected 8", busy2); end
        checks++; if (oData !== 8'h33) begin errors++; $display("FAIL b2b2_data got %h expected 33", oData); end
        checks++; if (oData_B !== 1'b0) begin errors++; $display("FAIL b2b2_borrow got %b expected 0", oData_B); end
        @(posedge iClk); #1;
        checks++; if (oDone !== 1'b0) begin errors++; $display("FAIL b2b2_done_width got %b expected 0", oDone); end
    endtask

    task automatic test_ignore_start();
        int doneCnt = 0; int doneAt = -1;
        logic [W-1:0] gotD = '0; logic gotB = 1'b0;
        iData_a = 8'h45; iData_b = 8'hE2; iB = 1'b1; iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            iStart = (k == 3);
            if (k == 3) begin iData_a = 8'hAD; iData_b = 8'hB2; iB = 1'b0; end
            @(posedge iClk); #1;
            if (oDone === 1'b1) begin doneCnt++; doneAt = k; gotD = oData; gotB = oData_B; end
        end
        iStart = 1'b0;
        checks++; if (doneCnt !== 1) begin errors++; $display("FAIL ignore_done_count got %0d expected 1", doneCnt); end
        checks++; if (doneAt !== 8) begin errors++; $display("FAIL ignore_done_cycle got %0d expected 8", doneAt); end
        checks++; if (gotD !== 8'h62) begin errors++; $display("FAIL ignore_data got %h expected 62", gotD); end
        checks++; if (gotB !== 1'b1) begin errors++; $display("FAIL ignore_borrow got %b expected 1", gotB); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart got %b expected 0", oBusy); end
    endtask

    task automatic test_reset_midop();
        int lat, busy; bit to; time t; int doneCnt = 0;
        iData_a = 8'hAD; iData_b = 8'hB2; iB = 1'b0; iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        repeat (4) @(posedge iClk);
        #3;
        iRst = 1'b1;
        #1;
        checks++; if (oData !== 8'h00) begin errors++; $display("FAIL midrst_data got %h expected 00", oData); end
        checks++; if (oData_B !== 1'b0) begin errors++; $display("FAIL midrst_borrow got %b expected 0", oData_B); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b expected 0", oBusy); end
        @(posedge iClk); #3;
        iRst = 1'b0;
        @(posedge iClk); #1;
        for (int k = 0; k < 10; k++) begin
            if (oDone === 1'b1) doneCnt++;
            @(posedge iClk); #1;
        end
        checks++; if (doneCnt !== 0) begin errors++; $display("FAIL midrst_abandoned_done got %0d expected 0", doneCnt); end
        doOp(8'hAD, 8'hB2, 1'b0, lat, busy, to, t);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL postrst_timeout got %b expected 0", to); end
        checks++; if (oData !== 8'hFB) begin errors++; $display("FAIL postrst_data got %h expected FB", oData); end
        checks++; if (oData_B !== 1'b1) begin errors++; $display("FAIL postrst_borrow got %b expected 1", oData_B); end
        @(posedge iClk); #1;
    endtask

    task automatic test_operand_change();
        int holdBad = 0; int doneAt = -1;
        iData_a = 8'h3C; iData_b = 8'h0F; iB = 1'b1; iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        iData_a = 8'h00; iData_b = 8'hFF; iB = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (oDone !== 1'b1 && doneAt < 0 && oData !== 8'hFB) holdBad++;
            @(posedge iClk); #1;
            if (oDone === 1'b1 && doneAt < 0) begin
                doneAt = k;
                checks++; if (oData !== 8'h2C) begin errors++; $display("FAIL capture_data got %h expected 2C", oData); end
                checks++; if (oData_B !== 1'b0) begin errors++; $display("FAIL capture_borrow got %b expected 0", oData_B); end
            end
        end
        checks++; if (doneAt !== 8) begin errors++; $display("FAIL capture_done_cycle got %0d expected 8", doneAt); end
        checks++; if (holdBad !== 0) begin errors++; $display("FAIL capture_hold_prev got %0d bad cycles expected 0", holdBad); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_back_to_back();
        test_ignore_start();
        test_reset_midop();
        test_operand_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
